// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the 3-master PCI round-robin arbiter.
package pci_arb_pkg;

   localparam int N_MASTERS     = 3;
   localparam int FRAME_TIMEOUT = 16;
   localparam int DATA_TIMEOUT  = 8;
   localparam int CNT_W         = 5;

   localparam logic [2:0]       GNT_NONE = 3'b111;
   localparam logic [CNT_W-1:0] FRAME_TC = CNT_W'(FRAME_TIMEOUT);
   localparam logic [CNT_W-1:0] DATA_TC  = CNT_W'(DATA_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      BUSY
   } arb_state_t;

   // Active-low one-hot GNT# for a master index.
   function automatic logic [2:0] gnt_of(input logic [1:0] idx);
      return ~(3'b001 << idx);
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority pick: first active requester starting at ptr.
module rr_priority_select
   import pci_arb_pkg::*;
(
   input  logic [1:0] ptr,
   input  logic [2:0] req,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand_0;
   logic [1:0] cand_1;
   logic [1:0] cand_2;

   always_comb begin
      cand_0 = ptr;
      cand_1 = next_idx(cand_0);
      cand_2 = next_idx(cand_1);
      valid  = |req;
      idx    = cand_0;
      if (req[cand_0])
         idx = cand_0;
      else if (req[cand_1])
         idx = cand_1;
      else if (req[cand_2])
         idx = cand_2;
   end

endmodule

// File: rtl/pci_rr_arbiter.sv
// 3-master PCI arbiter with rotating priority and FRAME#/data-phase timeouts.
// Optional bus parking on the last-granted master with ARB_BUS_PARK_EN.
//
// state | meaning
// IDLE  | no grant held (or parked); arbitrate pending REQ#
// GRANT | grant issued, waiting for FRAME# (FRAME_TIMEOUT limit)
// BUSY  | transaction in progress (DATA_TIMEOUT limit)
module pci_rr_arbiter
   import pci_arb_pkg::*;
(
   input  logic       clk,
   input  logic       _reset,
   input  logic [2:0] _req,
   input  logic       _frame,
   input  logic       _IRDY,
   output logic [2:0] final_gnt
);

   arb_state_t       state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] cnt_inc;
   logic             sel_valid;
   logic [1:0]       sel_idx;
`ifdef ARB_BUS_PARK_EN
   logic [1:0]       park_idx;
`endif

   rr_priority_select u_sel (
      .ptr   (ptr),
      .req   (~_req),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   assign cnt_inc = (counter == '1) ? counter : counter + CNT_W'(1);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         counter   <= '0;
         final_gnt <= GNT_NONE;
`ifdef ARB_BUS_PARK_EN
         park_idx  <= 2'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               counter <= '0;
               if (sel_valid) begin
                  final_gnt <= gnt_of(sel_idx);
                  ptr       <= next_idx(sel_idx);
                  state     <= GRANT;
`ifdef ARB_BUS_PARK_EN
                  park_idx  <= sel_idx;
`endif
               end else begin
`ifdef ARB_BUS_PARK_EN
                  final_gnt <= gnt_of(park_idx);
`else
                  final_gnt <= GNT_NONE;
`endif
               end
            end
            GRANT: begin
               if (!_frame) begin
                  state   <= BUSY;
                  counter <= '0;
               end else begin
                  counter <= cnt_inc;
                  if (cnt_inc == FRAME_TC) begin
                     state     <= IDLE;
                     final_gnt <= GNT_NONE;
                  end
               end
            end
            BUSY: begin
               if (_frame && _IRDY) begin
                  state     <= IDLE;
                  final_gnt <= GNT_NONE;
               end else begin
                  counter <= cnt_inc;
                  if (cnt_inc == DATA_TC) begin
                     state     <= IDLE;
                     final_gnt <= GNT_NONE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               final_gnt <= GNT_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Self-checking bench for pci_rr_arbiter: directed scenarios plus random traffic vs a behavioural model.
module tb_pci_rr_arbiter;

   logic       clk = 1'b0;
   logic       _reset;
   logic [2:0] _req;
   logic       _frame;
   logic       _IRDY;
   logic [2:0] final_gnt;

   int n_vec = 0;
   int n_err = 0;

   // reference model: phase 0=idle 1=granted 2=transaction
   int         m_phase;
   int         m_ptr;
   int         m_cycles;
   int         m_last;
   logic [2:0] m_gnt;

   pci_rr_arbiter dut (
      .clk       (clk),
      ._reset    (_reset),
      ._req      (_req),
      ._frame    (_frame),
      ._IRDY     (_IRDY),
      .final_gnt (final_gnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_ptr    = 0;
      m_cycles = 0;
      m_last   = 0;
      m_gnt    = 3'b111;
   endtask

   task automatic model_step();
      int pick;
      pick = -1;
      case (m_phase)
         0: begin
            for (int k = 0; k < 3; k++) begin
               int c;
               c = (m_ptr + k) % 3;
               if (pick < 0 && _req[c[1:0]] == 1'b0) pick = c;
            end
            m_gnt = 3'b111;
            if (pick >= 0) begin
               m_gnt[pick[1:0]] = 1'b0;
               m_ptr    = (pick + 1) % 3;
               m_last   = pick;
               m_cycles = 0;
               m_phase  = 1;
            end else begin
`ifdef ARB_BUS_PARK_EN
               m_gnt[m_last[1:0]] = 1'b0;
`endif
            end
         end
         1: begin
            if (_frame == 1'b0) begin
               m_phase  = 2;
               m_cycles = 0;
            end else begin
               m_cycles++;
               if (m_cycles >= 16) begin
                  m_phase = 0;
                  m_gnt   = 3'b111;
               end
            end
         end
         default: begin
            if (_frame && _IRDY) begin
               m_phase = 0;
               m_gnt   = 3'b111;
            end else begin
               m_cycles++;
               if (m_cycles >= 8) begin
                  m_phase = 0;
                  m_gnt   = 3'b111;
               end
            end
         end
      endcase
   endtask

   task automatic drive(input logic [2:0] req, input logic frame, input logic irdy);
      _req   = req;
      _frame = frame;
      _IRDY  = irdy;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_val(tag, final_gnt, m_gnt);
   endtask

   task automatic pulse_reset(input string tag);
      _reset = 1'b0;
      #1;
      check_val(tag, final_gnt, 3'b111);
      model_reset();
      @(negedge clk);
      _reset = 1'b1;
   endtask

   initial begin
      drive(3'b111, 1'b1, 1'b1);
      _reset = 1'b0;
      model_reset();
      #12;
      check_val("reset", final_gnt, 3'b111);
      @(negedge clk);
      _reset = 1'b1;

      // 1: master 0 grant, transaction, release
      drive(3'b110, 1'b0, 1'b0);
      step("t1_grant");
      check_val("t1_gnt_m0", final_gnt, 3'b110);
      drive(3'b111, 1'b0, 1'b0);
      step("t1_busy");
      drive(3'b111, 1'b1, 1'b0);
      step("t1_frame_hi");
      drive(3'b111, 1'b1, 1'b1);
      step("t1_done");
      check_val("t1_release", final_gnt, 3'b111);

      // 2: masters 0,1 with ptr=1 -> master 1
      drive(3'b100, 1'b1, 1'b1);
      step("t2_grant");
      check_val("t2_gnt_m1", final_gnt, 3'b101);
      drive(3'b111, 1'b0, 1'b0);
      step("t2_busy");

      // 3: data-phase timeout at the 8th edge in BUSY
      for (int i = 0; i < 7; i++) step("t3_hold");
      check_val("t3_still_held", final_gnt, 3'b101);
      step("t3_timeout");
      check_val("t3_released", final_gnt, 3'b111);
      drive(3'b111, 1'b1, 1'b1);
      step("t3_idle");

      // 4: master 2 with ptr=2
      drive(3'b010, 1'b1, 1'b1);
      step("t4_grant");
      check_val("t4_gnt_m2", final_gnt, 3'b011);
      drive(3'b111, 1'b0, 1'b0);
      step("t4_busy");
      drive(3'b111, 1'b1, 1'b1);
      step("t4_done");

      // 5: all request with ptr=0, FRAME# never asserted
      drive(3'b000, 1'b1, 1'b1);
      step("t5_grant");
      check_val("t5_gnt_m0", final_gnt, 3'b110);
      for (int i = 0; i < 15; i++) step("t5_wait");
      check_val("t5_still_held", final_gnt, 3'b110);
      step("t5_timeout");
      check_val("t5_released", final_gnt, 3'b111);

      // 6: async reset mid-BUSY, then ptr back at 0
      drive(3'b011, 1'b1, 1'b1);
      step("t6_grant");
      check_val("t6_gnt_m2", final_gnt, 3'b011);
      drive(3'b111, 1'b0, 1'b0);
      step("t6_busy");
      pulse_reset("t6_async_reset");
      drive(3'b000, 1'b1, 1'b1);
      step("t6_ptr0");
      check_val("t6_gnt_m0", final_gnt, 3'b110);
      drive(3'b111, 1'b0, 1'b0);
      step("t6_busy2");
      drive(3'b111, 1'b1, 1'b1);
      step("t6_done");
      step("t6_idle_park");
      step("t6_idle_park2");
`ifdef ARB_BUS_PARK_EN
      check_val("t6_parked", final_gnt, 3'b110);
`else
      check_val("t6_no_park", final_gnt, 3'b111);
`endif

      // random traffic in blocks with varying FRAME#/IRDY# bias
      for (int blk = 0; blk < 8; blk++) begin
         int frame_lo_pct;
         int irdy_lo_pct;
         frame_lo_pct = (blk % 4 == 0) ? 5 : (blk % 4 == 1) ? 90 : 50;
         irdy_lo_pct  = (blk % 2 == 0) ? 30 : 70;
         for (int i = 0; i < 150; i++) begin
            logic [2:0] r;
            r = ($urandom_range(0, 99) < 35) ? 3'b111 : 3'($urandom_range(0, 7));
            drive(r,
                  ($urandom_range(0, 99) < frame_lo_pct) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < irdy_lo_pct) ? 1'b0 : 1'b1);
            step("rand");
            if ($urandom_range(0, 199) == 0) pulse_reset("rand_reset");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
